fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch stage between instruction memory (im) and the ir/ctrl consumer.
//  Drives the fetch address and buffers fetched words with their addresses in a DEPTH-entry FIFO.
//  Presents the head word to the consumer; the consumer pops it with ir_load.
//  On a taken branch or jump, the queue is flushed and fetch restarts at the redirect address.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >=2
//  AW     16  fetch address width; word-addressed
//  DW     32  instruction width
// PORTS
//  clk            in   1              system clock; all state updates on rising edge
//  rst_f          in   1              reset; synchronous, active-high
//  im_addr        out  AW             fetch address to im; equals internal fetch_pc
//  im_data        in   DW             instruction word from im; combinational on im_addr, same cycle
//  fetch_en       in   1              1 = fetching permitted this cycle
//  ir_load        in   1              consumer pops head entry
//  redirect       in   1              taken branch/jump; flush and refetch
//  redirect_addr  in   AW             new fetch address when redirect=1
//  instr          out  DW             head instruction; 0 when queue empty
//  instr_pc       out  AW             address of head instruction; 0 when empty
//  instr_valid    out  1              queue non-empty
//  q_count        out  clog2(DEPTH)+1 current entry count, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_f=1 at edge): fetch_pc=0, rd_ptr=wr_ptr=0, q_count=0. Outputs: im_addr=0, instr=0,
//    instr_pc=0, instr_valid=0. Reset overrides redirect, fetch_en and ir_load.
//  Priority each edge: rst_f > redirect > normal push/pop.
//  pop  = ir_load & instr_valid & ~redirect; ir_load while empty is ignored (no underflow).
//  push = fetch_en & ~redirect & (q_count<DEPTH | pop); full plus pop in the same cycle still pushes.
//  On push: store {fetch_pc, im_data} at wr_ptr; wr_ptr+=1 mod DEPTH; fetch_pc+=1 mod 2^AW (0xFFFF->0).
//  On pop: rd_ptr+=1 mod DEPTH.
//  q_count += push - pop; push and pop together leave it unchanged.
//  instr/instr_pc/instr_valid are combinational from the head entry and q_count.
//  No bypass: a word pushed at edge N is visible at instr after edge N only (1-cycle latency).
//  Redirect at edge N: q_count=0, pointers=0, fetch_pc=redirect_addr, no push, no pop.
//    instr_valid=0 during cycle N+1; im_addr=redirect_addr in N+1.
//    The first new word is visible after edge N+1 if fetch_en=1 then.
//  Full (q_count=DEPTH), no pop: fetch_pc holds; im_addr stable; im_data ignored.
//  fetch_en=0: no push; fetch_pc holds; pops continue normally.
//  Steady state (fetch_en=1, ir_load=1 every cycle): one instruction per cycle, no bubbles
//    after the initial 1-cycle fill.
//  Queue contents are never read when q_count=0; stale entries are not visible.
// TESTING
//  1 Reset, then fetch_en=1, ir_load=0; im model mem[i]=32'hA000_0000+i
//    -> after 4 edges: q_count=4, instr=A0000000, instr_pc=0, im_addr=4 and held.
//  2 Scenario 1 full, then ir_load=1 for 6 cycles
//    -> instr_pc 0,1,2,3,4,5 on consecutive cycles; q_count stays 4 (pop+push each cycle).
//  3 Empty queue, fetch_en=0, ir_load=1 for 3 cycles
//    -> q_count=0, instr_valid=0, instr=0, im_addr unchanged.
//  4 Queue holding 3, redirect=1 with redirect_addr=16'h0020, ir_load=1
//    -> next cycle: instr_valid=0, q_count=0, im_addr=0020;
//       after the next edge: instr=A0000020, instr_pc=0020.
//  5 redirect=1 and rst_f=1 in the same cycle, redirect_addr=16'h0040
//    -> im_addr=0, q_count=0, instr=0.
//  6 redirect_addr=16'hFFFF, fetch_en=1
//    -> entries with pc FFFF then 0000; im_addr wraps to 0001 after two pushes.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue; fetches sequential words from im,
//               buffers {pc, word} pairs and presents the head to the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_f,
    output logic [AW-1:0]            im_addr,
    input  logic [DW-1:0]            im_data,
    input  logic                     fetch_en,
    input  logic                     ir_load,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_addr,
    output logic [DW-1:0]            instr,
    output logic [AW-1:0]            instr_pc,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [AW-1:0]      r_fetch_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DW-1:0]      r_mem_data [DEPTH];
    logic [AW-1:0]      r_mem_pc   [DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_valid = (r_count != '0);
    assign w_pop   = ir_load & w_valid & ~redirect;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign w_push  = fetch_en & ~redirect & ((r_count != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_fetch_pc <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_addr;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed while q_count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst_f && w_push) begin
            r_mem_data[r_wr_ptr] <= im_data;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign im_addr     = r_fetch_pc;
    assign instr_valid = w_valid;
    assign q_count     = r_count;
    assign instr       = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            rst_f;
    logic [AW-1:0]   im_addr;
    logic [DW-1:0]   im_data;
    logic            fetch_en;
    logic            ir_load;
    logic            redirect;
    logic [AW-1:0]   redirect_addr;
    logic [DW-1:0]   instr;
    logic [AW-1:0]   instr_pc;
    logic            instr_valid;
    logic [2:0]      q_count;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .im_addr       (im_addr),
        .im_data       (im_data),
        .fetch_en      (fetch_en),
        .ir_load       (ir_load),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[i] = A000_0000 + i
    assign im_data = 32'hA000_0000 + {16'h0000, im_addr};

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        m_q[$];
    logic [AW-1:0] m_pc;
    bit            m_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: FIFO of {pc, word}, advanced on each rising edge.
    always @(posedge clk) begin
        bit pop, push;
        if (rst_f) begin
            m_q.delete();
            m_pc = '0;
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_addr;
        end else begin
            pop  = ir_load && (m_q.size() > 0);
            push = fetch_en && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, 32'hA000_0000 + {16'h0000, m_pc}});
                m_pc = m_pc + 16'd1;
            end
        end
        m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("cyc_im_addr", 48'(im_addr), 48'(m_pc));
            check("cyc_q_count", 48'(q_count), 48'(m_q.size()));
            check("cyc_valid",   48'(instr_valid), 48'(m_q.size() > 0));
            check("cyc_instr",   48'(instr), (m_q.size() > 0) ? 48'(m_q[0].data) : 48'd0);
            check("cyc_pc",      48'(instr_pc), (m_q.size() > 0) ? 48'(m_q[0].pc) : 48'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_f = 1'b1; fetch_en = 1'b0; ir_load = 1'b0;
        redirect = 1'b0; redirect_addr = '0;
        repeat (2) tick();
        rst_f = 1'b0;
        check("rst_im_addr", 48'(im_addr), 48'd0);
        check("rst_count",   48'(q_count), 48'd0);
        check("rst_instr",   48'(instr), 48'd0);
        check("rst_valid",   48'(instr_valid), 48'd0);

        // Fill to full, then fetch holds
        fetch_en = 1'b1;
        repeat (4) tick();
        check("s1_count",   48'(q_count), 48'd4);
        check("s1_instr",   48'(instr), 48'hA000_0000);
        check("s1_pc",      48'(instr_pc), 48'd0);
        check("s1_im_addr", 48'(im_addr), 48'd4);
        tick();
        check("s1_hold_im_addr", 48'(im_addr), 48'd4);
        check("s1_hold_count",   48'(q_count), 48'd4);

        // Streaming pop+push while full
        ir_load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("s2_pc",    48'(instr_pc), 48'(i));
            check("s2_count", 48'(q_count), 48'd4);
            tick();
        end

        // Drain, then pop on empty
        fetch_en = 1'b0;
        repeat (4) tick();
        repeat (3) tick();
        check("s3_count",   48'(q_count), 48'd0);
        check("s3_valid",   48'(instr_valid), 48'd0);
        check("s3_instr",   48'(instr), 48'd0);
        check("s3_im_addr", 48'(im_addr), 48'd10);

        // Redirect with 3 queued
        ir_load = 1'b0; fetch_en = 1'b1;
        repeat (3) tick();
        check("s4_count_pre", 48'(q_count), 48'd3);
        redirect = 1'b1; redirect_addr = 16'h0020; ir_load = 1'b1;
        tick();
        redirect = 1'b0; ir_load = 1'b0;
        check("s4_valid",   48'(instr_valid), 48'd0);
        check("s4_count",   48'(q_count), 48'd0);
        check("s4_im_addr", 48'(im_addr), 48'h0020);
        tick();
        check("s4_instr", 48'(instr), 48'hA000_0020);
        check("s4_pc",    48'(instr_pc), 48'h0020);

        // Reset beats redirect
        rst_f = 1'b1; redirect = 1'b1; redirect_addr = 16'h0040;
        tick();
        rst_f = 1'b0; redirect = 1'b0; fetch_en = 1'b0;
        check("s5_im_addr", 48'(im_addr), 48'd0);
        check("s5_count",   48'(q_count), 48'd0);
        check("s5_instr",   48'(instr), 48'd0);

        // Fetch address wrap
        redirect = 1'b1; redirect_addr = 16'hFFFF; fetch_en = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (2) tick();
        check("s6_count",   48'(q_count), 48'd2);
        check("s6_pc",      48'(instr_pc), 48'hFFFF);
        check("s6_instr",   48'(instr), 48'hA000_FFFF);
        check("s6_im_addr", 48'(im_addr), 48'h0001);
        ir_load = 1'b1;
        tick();
        check("s6_pc_wrap",    48'(instr_pc), 48'h0000);
        check("s6_instr_wrap", 48'(instr), 48'hA000_0000);
        check("s6_count_wrap", 48'(q_count), 48'd2);
        repeat (5) tick();

        ir_load = 1'b0; fetch_en = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
